rr_arb_merge_nxw: RTL and testbench

Parametrised round-robin N-to-1 arbitrated merge, the synchronous successor of the fixed 5-channel/32-bit merge. It is intended for router output ports and FPGA prototyping of the NoC.
Each input channel has its own FIFO buffer. A work-conserving round-robin arbiter drains the FIFOs into a single registered valid/ready output stage.
Source channel ID is exported, and optional packet locking keeps multi-flit packets contiguous.

---
 rtl/rr_arb_merge_nxw.sv | 192 +++++++++++++++++++
 tb/tb_rr_arb_merge_nxw.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_merge_nxw.sv
// ============================================================================
//  Module   : rr_arb_merge_nxw
//  Brief    : N-to-1 round-robin merge with per-channel FIFOs, a registered
//             valid/ready output stage and source-ID export. Packet locking
//             is compiled in with `define ARB_MERGE_PKT_LOCK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb_merge_nxw #(
    parameter int  NUM_CH   = 5,
    parameter int  DATA_W   = 32,
    parameter int  IN_DEPTH = 2,
    localparam int CH_W     = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [CH_W-1:0]          out_src
);

    localparam int              AW       = $clog2(IN_DEPTH);
    localparam int              FW       = DATA_W + 1;
    localparam logic [AW:0]     c_depth  = (AW+1)'(IN_DEPTH);
    localparam logic [CH_W:0]   c_num_ch = (CH_W+1)'(NUM_CH);
    localparam logic [CH_W-1:0] c_last_ch = CH_W'(NUM_CH - 1);

    logic [NUM_CH-1:0] w_push;
    logic [NUM_CH-1:0] w_pop;
    logic [NUM_CH-1:0] w_nonempty;
    logic [FW-1:0]     w_head [NUM_CH];

    logic              w_load;
    logic              w_gnt_vld;
    logic [CH_W-1:0]   w_gnt_ch;
    logic [CH_W-1:0]   w_gnt_inc;
    logic [CH_W:0]     w_idx;
    logic [FW-1:0]     w_gnt_head;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_last_q,  out_last_d;
    logic [CH_W-1:0]   out_src_q,   out_src_d;
    logic [CH_W-1:0]   ptr_q,       ptr_d;
`ifdef ARB_MERGE_PKT_LOCK_EN
    logic              lock_q,      lock_d;
    logic [CH_W-1:0]   lock_ch_q,   lock_ch_d;
`endif

    // ------------------------------------------------------------------------
    // Per-channel FIFOs; in_ready depends only on the registered count
    // ------------------------------------------------------------------------
    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_fifo
            logic [FW-1:0] mem_q [IN_DEPTH];
            logic [AW-1:0] wr_q;
            logic [AW-1:0] rd_q;
            logic [AW:0]   cnt_q;

            assign in_ready[k]   = rst & (cnt_q != c_depth);
            assign w_push[k]     = in_valid[k] & in_ready[k];
            assign w_nonempty[k] = (cnt_q != '0);
            assign w_head[k]     = mem_q[rd_q];
            assign w_pop[k]      = w_load & w_gnt_vld & (w_gnt_ch == CH_W'(k));

            always_ff @(posedge clk) begin
                if (w_push[k]) begin
                    mem_q[wr_q] <= {in_last[k], in_data[k*DATA_W +: DATA_W]};
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    wr_q  <= '0;
                    rd_q  <= '0;
                    cnt_q <= '0;
                end else begin
                    if (w_push[k]) wr_q <= wr_q + 1'b1;
                    if (w_pop[k])  rd_q <= rd_q + 1'b1;
                    if (w_push[k] && !w_pop[k]) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else if (!w_push[k] && w_pop[k]) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Round-robin arbitration starting at ptr_q (or pinned to lock_ch_q)
    // ------------------------------------------------------------------------
    assign w_load = ~out_valid_q | out_ready;

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_ch  = '0;
        w_idx     = '0;
`ifdef ARB_MERGE_PKT_LOCK_EN
        if (lock_q) begin
            if (w_nonempty[lock_ch_q]) begin
                w_gnt_vld = 1'b1;
                w_gnt_ch  = lock_ch_q;
            end
        end else
`endif
        begin
            for (int i = 0; i < NUM_CH; i++) begin
                w_idx = {1'b0, ptr_q} + (CH_W+1)'(i);
                if (w_idx >= c_num_ch) w_idx = w_idx - c_num_ch;
                if (!w_gnt_vld && w_nonempty[w_idx[CH_W-1:0]]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_ch  = w_idx[CH_W-1:0];
                end
            end
        end
    end

    assign w_gnt_inc  = (w_gnt_ch == c_last_ch) ? '0 : w_gnt_ch + 1'b1;
    assign w_gnt_head = w_head[w_gnt_ch];

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;
`ifdef ARB_MERGE_PKT_LOCK_EN
        lock_d      = lock_q;
        lock_ch_d   = lock_ch_q;
`endif
        if (w_load) begin
            out_valid_d = w_gnt_vld;
            if (w_gnt_vld) begin
                out_data_d = w_gnt_head[DATA_W-1:0];
                out_last_d = w_gnt_head[DATA_W];
                out_src_d  = w_gnt_ch;
`ifdef ARB_MERGE_PKT_LOCK_EN
                // Pointer only moves past a channel once its packet tail leaves
                if (w_gnt_head[DATA_W]) begin
                    lock_d = 1'b0;
                    ptr_d  = w_gnt_inc;
                end else begin
                    lock_d    = 1'b1;
                    lock_ch_d = w_gnt_ch;
                end
`else
                ptr_d = w_gnt_inc;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
            ptr_q       <= '0;
`ifdef ARB_MERGE_PKT_LOCK_EN
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
`ifdef ARB_MERGE_PKT_LOCK_EN
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arb_merge_nxw.sv
// ============================================================================
//  Module   : tb_rr_arb_merge_nxw
//  Brief    : Directed self-checking bench for rr_arb_merge_nxw (5 x 32-bit).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arb_merge_nxw;

    localparam int NUM_CH = 5;
    localparam int DATA_W = 32;

    logic                     clk;
    logic                     rst;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic                     out_last;
    logic [2:0]               out_src;

    int n_tests = 0;
    int n_fail  = 0;

    rr_arb_merge_nxw #(
        .NUM_CH   (NUM_CH),
        .DATA_W   (DATA_W),
        .IN_DEPTH (2)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flit(input int k, input logic [31:0] d, input logic l);
        in_valid[k]              = 1'b1;
        in_data[k*DATA_W +: DATA_W] = d;
        in_last[k]               = l;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        in_last   = '0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        in_valid  = '1;
        in_data   = '0;
        in_last   = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (in_ready !== 5'h00) begin n_fail++; $display("FAIL reset_in_ready: got %h exp 00", in_ready); end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        n_tests++;
        if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h exp 0", out_data); end
        n_tests++;
        if (out_src !== 3'd0) begin n_fail++; $display("FAIL reset_out_src: got %0d exp 0", out_src); end
        rst      = 1'b1;
        in_valid = '0;
        tick();
        n_tests++;
        if (in_ready !== 5'h1F) begin n_fail++; $display("FAIL reset_release_in_ready: got %h exp 1f", in_ready); end
    endtask

    task automatic test_single();
        do_reset();
        set_flit(2, 32'hA5A50002, 1'b1);
        tick();
        in_valid = '0;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency: got %b exp 0", out_valid); end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5A50002 || out_src !== 3'd2) begin
            n_fail++;
            $display("FAIL single_out: got v=%b d=%h s=%0d exp v=1 d=a5a50002 s=2", out_valid, out_data, out_src);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b exp 0", out_valid); end
        // ptr is now 3, so ch3 must win over ch1
        set_flit(1, 32'h21, 1'b1);
        set_flit(3, 32'h23, 1'b1);
        tick();
        in_valid = '0;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_src !== 3'd3 || out_data !== 32'h23) begin
            n_fail++;
            $display("FAIL single_ptr_first: got v=%b s=%0d d=%h exp v=1 s=3 d=23", out_valid, out_src, out_data);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_src !== 3'd1 || out_data !== 32'h21) begin
            n_fail++;
            $display("FAIL single_ptr_second: got v=%b s=%0d d=%h exp v=1 s=1 d=21", out_valid, out_src, out_data);
        end
    endtask

    task automatic test_contention();
        do_reset();
        for (int k = 0; k < NUM_CH; k++) set_flit(k, 32'h10 + k, 1'b1);
        tick();
        in_valid = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || out_src !== 3'(k) || out_data !== 32'h10 + k) begin
                n_fail++;
                $display("FAIL contention_grant%0d: got v=%b s=%0d d=%h exp v=1 s=%0d d=%h",
                         k, out_valid, out_src, out_data, k, 32'h10 + k);
            end
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL contention_idle: got %b exp 0", out_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        set_flit(0, 32'd1, 1'b1);
        tick();
        set_flit(0, 32'd2, 1'b1);
        tick();
        set_flit(0, 32'd3, 1'b1);
        tick();
        set_flit(0, 32'd4, 1'b1);
        n_tests++;
        if (in_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_full: got %b exp 0", in_ready[0]); end
        tick();
        in_valid = '0;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 32'd1) begin
            n_fail++;
            $display("FAIL bp_hold: got v=%b d=%h exp v=1 d=1", out_valid, out_data);
        end
        tick();
        n_tests++;
        if (out_data !== 32'd1 || in_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stable: got d=%h rdy=%b exp d=1 rdy=0", out_data, in_ready[0]);
        end
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 32'd2 || in_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release2: got v=%b d=%h rdy=%b exp v=1 d=2 rdy=1", out_valid, out_data, in_ready[0]);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 32'd3) begin
            n_fail++;
            $display("FAIL bp_release3: got v=%b d=%h exp v=1 d=3", out_valid, out_data);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_fourth: got %b exp 0", out_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        set_flit(3, 32'h33, 1'b1);
        tick();
        in_valid = '0;
        tick();
        tick();
        set_flit(0, 32'h40, 1'b1);
        set_flit(4, 32'h44, 1'b1);
        tick();
        in_valid = '0;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_src !== 3'd4 || out_data !== 32'h44) begin
            n_fail++;
            $display("FAIL wrap_ch4: got v=%b s=%0d d=%h exp v=1 s=4 d=44", out_valid, out_src, out_data);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_src !== 3'd0 || out_data !== 32'h40) begin
            n_fail++;
            $display("FAIL wrap_ch0: got v=%b s=%0d d=%h exp v=1 s=0 d=40", out_valid, out_src, out_data);
        end
        tick();
        set_flit(0, 32'h50, 1'b1);
        set_flit(3, 32'h53, 1'b1);
        tick();
        in_valid = '0;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_src !== 3'd3 || out_data !== 32'h53) begin
            n_fail++;
            $display("FAIL wrap2_ch3: got v=%b s=%0d d=%h exp v=1 s=3 d=53", out_valid, out_src, out_data);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_src !== 3'd0 || out_data !== 32'h50) begin
            n_fail++;
            $display("FAIL wrap2_ch0: got v=%b s=%0d d=%h exp v=1 s=0 d=50", out_valid, out_src, out_data);
        end
    endtask

    task automatic test_pkt_lock();
        logic [2:0]  exp_s [4];
        logic [31:0] exp_d [4];
        logic        exp_l [4];
`ifdef ARB_MERGE_PKT_LOCK_EN
        exp_s = '{3'd1, 3'd1, 3'd2, 3'd2};
        exp_d = '{32'hA1, 32'hA2, 32'hB1, 32'hB2};
        exp_l = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_s = '{3'd1, 3'd2, 3'd1, 3'd2};
        exp_d = '{32'hA1, 32'hB1, 32'hA2, 32'hB2};
        exp_l = '{1'b0, 1'b0, 1'b1, 1'b1};
`endif
        do_reset();
        set_flit(1, 32'hA1, 1'b0);
        set_flit(2, 32'hB1, 1'b0);
        tick();
        set_flit(1, 32'hA2, 1'b1);
        set_flit(2, 32'hB2, 1'b1);
        tick();
        in_valid = '0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_src !== exp_s[i] || out_data !== exp_d[i] || out_last !== exp_l[i]) begin
                n_fail++;
                $display("FAIL pkt_flit%0d: got v=%b s=%0d d=%h l=%b exp v=1 s=%0d d=%h l=%b",
                         i, out_valid, out_src, out_data, out_last, exp_s[i], exp_d[i], exp_l[i]);
            end
            tick();
        end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pkt_idle: got %b exp 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < NUM_CH; k++) set_flit(k, 32'h60 + k, 1'b1);
        tick();
        in_valid = '0;
        tick();
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 5'h00) begin
            n_fail++;
            $display("FAIL midreset_async: got v=%b d=%h rdy=%h exp v=0 d=0 rdy=00", out_valid, out_data, in_ready);
        end
        tick();
        rst       = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_flushed%0d: got %b exp 0", i, out_valid); end
        end
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        in_last   = '0;
        out_ready = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_wrap();
        test_pkt_lock();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "bench timeout");
    end

endmodule

`default_nettype wire
